add_sequencer: RTL and testbench

ADD_SEQUENCER -- requirements
Module: add_sequencer

---
 rtl/add_seq_pkg.sv | 19 +
 rtl/add_sequencer_yadder.sv | 15 +
 rtl/add_sequencer.sv | 115 +++++++++++
 tb/tb_add_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the word-serial multi-word adder.
// Holds the FSM encoding, the word width and the default operand size.
package add_seq_pkg;

  localparam int WORD_W        = 32;
  localparam int WORDS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word-index width; never zero so single-word builds still get a real port.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/add_sequencer_yadder.sv
// yAdder: combinational W-bit adder with carry in/out; zero latency, no flow control.
// This is the only arithmetic on operand data in the sequencer.
module yAdder #(
  parameter int W = 32
) (
  output logic [W-1:0] z,
  output logic         cout,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin
);

  assign {cout, z} = a + b + {{W{1'b0}}, cin};

endmodule

// File: rtl/add_sequencer.sv
// add_sequencer: wide add done one 32-bit word per cycle; result valid nwords+1 cycles after accept.
// Result held in DONE until done_ready; no new request accepted until the cycle after leaving DONE.
module add_sequencer
  import add_seq_pkg::*;
#(
  parameter  int WORDS = WORDS_DEFAULT,
  localparam int IW    = idx_width(WORDS),
  localparam int DW    = WORD_W * WORDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  input  logic [IW-1:0] nwords,
  output logic          done_valid,
  input  logic          done_ready,
  output logic [DW-1:0] res,
  output logic          cout,
  output logic          ovf
);

  typedef struct packed {
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [IW-1:0] last;
  } req_t;

  state_t              state;
  state_t              state_nxt;
  req_t                req_q;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       nw_clamped;
  logic                carry;
  logic                accept;
  logic                last_word;
  logic [WORD_W-1:0]   opa;
  logic [WORD_W-1:0]   opb;
  logic [WORD_W-1:0]   sum;
  logic                add_co;

  // Only non-power-of-two WORDS can see an out-of-range word count.
  generate
    if ((1 << IW) > WORDS) begin : g_clamp
      localparam logic [IW-1:0] MAX_IDX = IW'(WORDS - 1);
      assign nw_clamped = (nwords > MAX_IDX) ? MAX_IDX : nwords;
    end else begin : g_pass
      assign nw_clamped = nwords;
    end
  endgenerate

  assign start_ready = (state == IDLE);
  assign accept      = start_valid && start_ready;
  assign last_word   = (idx == req_q.last);
  assign opa         = req_q.op_a[idx*WORD_W +: WORD_W];
  assign opb         = req_q.op_b[idx*WORD_W +: WORD_W];

  yAdder #(.W(WORD_W)) u_adder (
    .z    (sum),
    .cout (add_co),
    .a    (opa),
    .b    (opb),
    .cin  (carry)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_valid) state_nxt = RUN;
      RUN:     if (last_word)   state_nxt = DONE;
      DONE:    if (done_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Carry is seeded with cin on accept so nothing leaks between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      res        <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      done_valid <= (state_nxt == DONE);
      if (accept) begin
        req_q <= '{op_a: a, op_b: b, last: nw_clamped};
        idx   <= '0;
        carry <= cin;
        res   <= '0;
      end else if (state == RUN) begin
        res[idx*WORD_W +: WORD_W] <= sum;
        carry                     <= add_co;
        idx                       <= idx + 1'b1;
        if (last_word) begin
          cout <= add_co;
          ovf  <= (opa[WORD_W-1] == opb[WORD_W-1]) && (sum[WORD_W-1] != opa[WORD_W-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_add_sequencer.sv
// Directed and random checks of add_sequencer against hand-computed values and a wide-add model.
module tb_add_sequencer;

  localparam int DW = 128;

  logic          clk;
  logic          rst_n;
  logic          start_valid;
  logic          start_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          cin;
  logic [1:0]    nwords;
  logic          done_valid;
  logic          done_ready;
  logic [DW-1:0] res;
  logic          cout;
  logic          ovf;

  int n_assert;
  int n_fail;
  int lat;
  int w;
  int bp;
  logic [DW:0]   mask;
  logic [DW:0]   full;
  logic [DW-1:0] exp_res;
  logic          exp_cout;
  logic          exp_ovf;
  logic [DW-1:0] ra;
  logic [DW-1:0] rb;
  logic          rc;
  logic [1:0]    rn;

  add_sequencer #(.WORDS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .nwords      (nwords),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .res         (res),
    .cout        (cout),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [DW-1:0] pa, input logic [DW-1:0] pb,
                           input logic pc, input logic [1:0] pn);
    int t;
    t = 0;
    while (!start_ready && t < 50) begin
      tick();
      t++;
    end
    chk("start_ready_before_req", start_ready, 1);
    a = pa;
    b = pb;
    cin = pc;
    nwords = pn;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    while (!done_valid && l < 20) begin
      tick();
      l++;
    end
  endtask

  task automatic handshake();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    nwords      = '0;

    #12;
    chk("reset res", res, 0);
    chk("reset cout", cout, 0);
    chk("reset ovf", ovf, 0);
    chk("reset done_valid", done_valid, 0);
    chk("reset start_ready", start_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("start_ready after release", start_ready, 1);

    // single word wrap with carry out
    start_req(128'hFFFFFFFF, 128'h1, 1'b0, 2'd0);
    wait_done(lat);
    chk("w1 latency", lat, 1);
    chk("w1 res", res, 0);
    chk("w1 cout", cout, 1);
    chk("w1 ovf", ovf, 0);
    handshake();
    chk("w1 done_valid after hs", done_valid, 0);

    // carry ripples through all four words
    start_req({128{1'b1}}, 128'h1, 1'b0, 2'd3);
    wait_done(lat);
    chk("w4 latency", lat, 4);
    chk("w4 res", res, 0);
    chk("w4 cout", cout, 1);
    chk("w4 ovf", ovf, 0);
    handshake();

    // two words with cin; upper operand words must not appear in res
    start_req({64'hDEADBEEF_12345678, 64'h00000000_FFFFFFFF}, 128'h0, 1'b1, 2'd1);
    wait_done(lat);
    chk("w2 latency", lat, 2);
    chk("w2 res", res, 128'h00000000_00000000_00000001_00000000);
    chk("w2 cout", cout, 0);
    handshake();
    chk("idle done_valid", done_valid, 0);
    chk("idle start_ready", start_ready, 1);
    tick();
    chk("idle res kept", res, 128'h00000000_00000000_00000001_00000000);

    // signed overflow, then back-pressure with a competing request
    start_req(128'h7FFFFFFF, 128'h1, 1'b0, 2'd0);
    wait_done(lat);
    chk("ovf latency", lat, 1);
    chk("ovf res", res, 128'h80000000);
    chk("ovf ovf", ovf, 1);
    chk("ovf cout", cout, 0);
    a = {128{1'b1}};
    b = 128'h1;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold%0d res", i), res, 128'h80000000);
      chk($sformatf("hold%0d ovf", i), ovf, 1);
      chk($sformatf("hold%0d done_valid", i), done_valid, 1);
      chk($sformatf("hold%0d start_ready", i), start_ready, 0);
    end
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
    chk("hs cycle no accept", start_ready, 1);
    chk("hs done_valid low", done_valid, 0);
    tick();
    start_valid = 1'b0;
    chk("accept after idle", start_ready, 0);
    wait_done(lat);
    chk("late req latency", lat, 1);
    chk("late req res", res, 0);
    chk("late req cout", cout, 1);
    handshake();

    // asynchronous reset in the middle of a run
    start_req({128{1'b1}}, 128'h0, 1'b0, 2'd3);
    tick();
    tick();
    chk("partial res", res, 128'h00000000_00000000_FFFFFFFF_FFFFFFFF);
    rst_n = 1'b0;
    #1;
    chk("arst res", res, 0);
    chk("arst cout", cout, 0);
    chk("arst ovf", ovf, 0);
    chk("arst done_valid", done_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("arst start_ready", start_ready, 1);
    chk("arst done_valid after", done_valid, 0);

    // random requests with random back-pressure
    for (int i = 0; i < 200; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      rn = 2'($urandom_range(0, 3));
      w  = 32 * (int'(rn) + 1);
      mask     = ({{DW{1'b0}}, 1'b1} << w) - 1'b1;
      full     = ({1'b0, ra} & mask) + ({1'b0, rb} & mask) + {{DW{1'b0}}, rc};
      exp_res  = full[DW-1:0] & mask[DW-1:0];
      exp_cout = full[w];
      exp_ovf  = (ra[w-1] == rb[w-1]) && (full[w-1] != ra[w-1]);
      start_req(ra, rb, rc, rn);
      wait_done(lat);
      chk($sformatf("rand%0d latency", i), lat, int'(rn) + 1);
      chk($sformatf("rand%0d res", i), res, exp_res);
      chk($sformatf("rand%0d cout", i), cout, exp_cout);
      chk($sformatf("rand%0d ovf", i), ovf, exp_ovf);
      bp = $urandom_range(0, 3);
      for (int j = 0; j < bp; j++) tick();
      handshake();
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
